line_refill_unit: RTL and testbench
===================================

# line_refill_unit

Downstream memory-side stage of the direct-mapped instruction cache. On a cache line request it fetches the line from a 32-bit word-wide backing memory as `LineWords` sequential word reads, packs the words into one line, and returns the line to the cache with a single-cycle valid pulse. It absorbs variable memory latency, latches the line address, and handles requests withdrawn mid-fetch.

## Interface
Parameters:
- `LineWords`, default 4: words per cache line; must be a power of two ≥ 2.
- `LineSize`, default `32*LineWords`: line width in bits; derived, not overridable.
- `OffsetBits`, default `log2(4*LineWords)` = 4: byte-offset bits cleared in the line address.

Ports (clock and reset: one clock `clk_i`; reset `rstn_i` is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rstn_i` in 1: asynchronous active-low reset.
- `mem_addr_i` in 32: line address from the cache; the low `OffsetBits` bits are ignored.
- `mem_read_en_i` in 1: line request, held by the cache until it sees valid.
- `mem_read_valid_o` out 1: one-cycle pulse; the line is on `mem_read_data_o`.
- `mem_read_data_o` out `LineSize`: the assembled line; word k is at bits [32k+31:32k].
- `word_req_o` out 1: word read request to the backing memory.
- `word_addr_o` out 32: byte address of the requested word (4-byte aligned).
- `word_valid_i` in 1: the word response is valid this cycle.
- `word_data_i` in 32: word data.

## Operation
- States: IDLE, FETCH, RESP, DRAIN.
- **IDLE:**
  - On `mem_read_en_i`=1, latch base = `{mem_addr_i[31:OffsetBits], 0}`, clear the beat counter, and go to FETCH.
- **FETCH:**
  - `word_req_o`=1 and `word_addr_o` = base + 4·beat.
  - A beat completes when `word_req_o` && `word_valid_i` are both high in the same cycle.
  - On completion, write `word_data_i` into line slot [beat] and increment beat.
  - After the last beat (beat = `LineWords`-1), go to RESP.
- **RESP:**
  - `mem_read_valid_o`=1 for exactly one cycle.
  - Then go to DRAIN if `mem_read_en_i`=1, otherwise to IDLE.
- **DRAIN:**
  - Wait for `mem_read_en_i`=0, then go to IDLE.
  - This guarantees one refill per request and no duplicate fetch while the cache leaves its query state.
- **Abort:**
  - If `mem_read_en_i`=0 in FETCH, go to IDLE next cycle and discard partial data.
  - `mem_read_data_o` keeps its previous complete line.
  - A `word_valid_i` arriving in the abort cycle is ignored.
- **Address stability:**
  - Changes on `mem_addr_i` after latching are ignored until the next IDLE acceptance.
- **Line register:**
  - Partial words go into an internal staging register.
  - `mem_read_data_o` is updated only on entry to RESP, so it holds the last full line until the next line completes.
- **Beat counter:**
  - Width `log2(LineWords)`; wraps to 0 on the final beat.
  - Address arithmetic is 32-bit; the line never crosses the line boundary.

## Timing
- Reset values: state=IDLE; `mem_read_valid_o`=0; `mem_read_data_o`=0; `word_req_o`=0; `word_addr_o`=0; staging=0; beat=0.
- All outputs are registered or derived only from state and registers; there is no combinational path from inputs to outputs.
- Zero-wait memory (`word_valid_i` tied 1):
  - Request seen at cycle 0.
  - `word_req_o` high during cycles 1–4, one beat per cycle.
  - `mem_read_valid_o` high in cycle 5.
  - Latency is `LineWords`+1 cycles.
- With W wait cycles per beat, latency is `LineWords`·(W+1)+1.
- `word_addr_o` stays stable while `word_req_o`=1 and no response has arrived; it advances in the cycle after each completed beat.
- Reset mid-fetch drops `word_req_o` immediately (asynchronously) and clears all state.

## Structure
- Shared cache package holds:
  - `ByteOffsetBits`, `IndexBits`, `TagBits`, `NrWordsPerLine`, `LineSize`;
  - the refill state enum (IDLE, FETCH, RESP, DRAIN).
- The cache and this block both import the package.
- No sub-module: FSM, beat counter, and staging register fit in a single module.

## Test plan
- **Reset:** assert `rstn_i`=0 mid-FETCH → all outputs 0 in the same cycle; IDLE after release.
- **Zero-wait fill:** request 0x0000_1234, memory returns addr+0xA000_0000 → word addresses 0x1230/0x1234/0x1238/0x123C; valid pulse in cycle 5; data = {0xA000_123C, 0xA000_1238, 0xA000_1234, 0xA000_1230}.
- **Wait states:** 2-cycle latency per beat → `word_addr_o` held 3 cycles per beat; valid at cycle 13; exactly one pulse.
- **Address change:** switch `mem_addr_i` to 0x8000 during beat 2 → remaining beats still use 0x1238/0x123C.
- **Abort:** drop `mem_read_en_i` after beat 1 → IDLE next cycle; no valid pulse; `mem_read_data_o` unchanged. A new request to 0x40 fetches 0x40–0x4C from beat 0.
- **Hold after valid:** keep `mem_read_en_i` high 3 cycles past the pulse → DRAIN; no second `word_req_o` until en falls and rises again.

Source files
------------

// File: rtl/line_refill_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_refill_unit_pkg
// Purpose  : Shared instruction-cache geometry and refill FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package line_refill_unit_pkg;

  localparam int ByteOffsetBits = 4;
  localparam int IndexBits      = 6;
  localparam int TagBits        = 32 - IndexBits - ByteOffsetBits;
  localparam int NrWordsPerLine = 4;
  localparam int LineSize       = 32 * NrWordsPerLine;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } refill_state_e;

  // Field view of a cache byte address as used by the cache front end.
  typedef struct packed {
    logic [TagBits-1:0]        tag;
    logic [IndexBits-1:0]      index;
    logic [ByteOffsetBits-1:0] offset;
  } cache_addr_t;

endpackage
`default_nettype wire

// File: rtl/line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : line_refill_unit
// Purpose  : Fetches a cache line as sequential 32-bit word reads and returns
//            the packed line with a single-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module line_refill_unit
  import line_refill_unit_pkg::*;
#(
  parameter int LineWords  = NrWordsPerLine,
  parameter int OffsetBits = $clog2(4 * LineWords)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               mem_addr_i,
  input  logic                      mem_read_en_i,
  output logic                      mem_read_valid_o,
  output logic [32*LineWords-1:0]   mem_read_data_o,
  output logic                      word_req_o,
  output logic [31:0]               word_addr_o,
  input  logic                      word_valid_i,
  input  logic [31:0]               word_data_i
);

  localparam int          LineBits    = 32 * LineWords;
  localparam int          BeatBits    = $clog2(LineWords);
  localparam logic [31:0] c_base_mask = ~((32'd1 << OffsetBits) - 32'd1);
  localparam logic [BeatBits-1:0] c_last_beat = BeatBits'(LineWords - 1);

  refill_state_e         r_state;
  refill_state_e         w_state_next;
  logic [31:0]           r_base;
  logic [BeatBits-1:0]   r_beat;
  logic [LineBits-1:0]   r_staging;
  logic [LineBits-1:0]   r_line;
  logic [LineBits-1:0]   w_staging_next;
  logic                  w_beat_done;
  logic                  w_last_beat;

  // A response during the abort cycle (request withdrawn) must not count.
  assign w_beat_done = (r_state == FETCH) && mem_read_en_i && word_valid_i;
  assign w_last_beat = (r_beat == c_last_beat);

  always_comb begin
    w_staging_next = r_staging;
    w_staging_next[32*r_beat +: 32] = word_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (mem_read_en_i) w_state_next = FETCH;
      end
      FETCH: begin
        if (!mem_read_en_i)                  w_state_next = IDLE;
        else if (w_beat_done && w_last_beat) w_state_next = RESP;
      end
      RESP: begin
        w_state_next = mem_read_en_i ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!mem_read_en_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The visible line only changes when the final word lands, so an aborted
  // fetch leaves the previous complete line intact.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_base    <= '0;
      r_beat    <= '0;
      r_staging <= '0;
      r_line    <= '0;
    end else begin
      if ((r_state == IDLE) && mem_read_en_i) begin
        r_base <= mem_addr_i & c_base_mask;
        r_beat <= '0;
      end
      if (w_beat_done) begin
        r_staging <= w_staging_next;
        r_beat    <= r_beat + BeatBits'(1);
        if (w_last_beat) r_line <= w_staging_next;
      end
    end
  end

  assign word_req_o       = (r_state == FETCH);
  assign word_addr_o      = r_base + {{(30-BeatBits){1'b0}}, r_beat, 2'b00};
  assign mem_read_valid_o = (r_state == RESP);
  assign mem_read_data_o  = r_line;

endmodule
`default_nettype wire

// File: tb/tb_line_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_refill_unit
// Purpose  : Directed self-checking bench for line_refill_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_refill_unit;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [31:0]  mem_addr_i;
  logic         mem_read_en_i;
  logic         mem_read_valid_o;
  logic [127:0] mem_read_data_o;
  logic         word_req_o;
  logic [31:0]  word_addr_o;
  logic         word_valid_i;
  logic [31:0]  word_data_i;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] c_line_1230 =
    {32'hA000_123C, 32'hA000_1238, 32'hA000_1234, 32'hA000_1230};
  localparam logic [127:0] c_line_2000 =
    {32'hA000_200C, 32'hA000_2008, 32'hA000_2004, 32'hA000_2000};
  localparam logic [127:0] c_line_0040 =
    {32'hA000_004C, 32'hA000_0048, 32'hA000_0044, 32'hA000_0040};

  always #5 clk_i = ~clk_i;

  // Backing memory: each word holds its own address plus a fixed tag.
  assign word_data_i = word_addr_o + 32'hA000_0000;

  line_refill_unit dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .mem_addr_i       (mem_addr_i),
    .mem_read_en_i    (mem_read_en_i),
    .mem_read_valid_o (mem_read_valid_o),
    .mem_read_data_o  (mem_read_data_o),
    .word_req_o       (word_req_o),
    .word_addr_o      (word_addr_o),
    .word_valid_i     (word_valid_i),
    .word_data_i      (word_data_i)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    rstn_i        = 1'b0;
    mem_addr_i    = 32'h0;
    mem_read_en_i = 1'b0;
    word_valid_i  = 1'b0;
    step(); step();
    chk("rst_valid", mem_read_valid_o, 0);
    chk("rst_data",  mem_read_data_o,  0);
    chk("rst_req",   word_req_o,       0);
    chk("rst_addr",  word_addr_o,      0);
    rstn_i = 1'b1;
    step();
    chk("idle_req", word_req_o, 0);

    // Zero-wait fill of line 0x1230.
    mem_addr_i    = 32'h0000_1234;
    mem_read_en_i = 1'b1;
    word_valid_i  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      chk($sformatf("zw_req_b%0d", b),   word_req_o,       1);
      chk($sformatf("zw_addr_b%0d", b),  word_addr_o,      32'h1230 + 4*b);
      chk($sformatf("zw_valid_b%0d", b), mem_read_valid_o, 0);
    end
    step();
    chk("zw_valid_c5", mem_read_valid_o, 1);
    chk("zw_data",     mem_read_data_o,  c_line_1230);
    chk("zw_req_c5",   word_req_o,       0);
    mem_read_en_i = 1'b0;
    step();
    chk("zw_valid_c6", mem_read_valid_o, 0);
    chk("zw_data_hold", mem_read_data_o, c_line_1230);

    // Two wait cycles per beat: address held three cycles, valid at cycle 13.
    mem_addr_i    = 32'h0000_2000;
    mem_read_en_i = 1'b1;
    word_valid_i  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        step();
        chk($sformatf("ws_addr_b%0d_w%0d", b, w), word_addr_o, 32'h2000 + 4*b);
        chk($sformatf("ws_req_b%0d_w%0d", b, w), word_req_o, 1);
        chk($sformatf("ws_valid_b%0d_w%0d", b, w), mem_read_valid_o, 0);
        word_valid_i = (w == 2);
      end
    end
    step();
    chk("ws_valid_c13", mem_read_valid_o, 1);
    chk("ws_data",      mem_read_data_o,  c_line_2000);
    mem_read_en_i = 1'b0;
    step();
    chk("ws_single_pulse", mem_read_valid_o, 0);

    // Address change mid-fill is ignored; then hold en for drain.
    word_valid_i  = 1'b1;
    mem_addr_i    = 32'h0000_1234;
    mem_read_en_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      chk($sformatf("ac_addr_b%0d", b), word_addr_o, 32'h1230 + 4*b);
      if (b == 1) mem_addr_i = 32'h0000_8000;
    end
    step();
    chk("ac_valid", mem_read_valid_o, 1);
    chk("ac_data",  mem_read_data_o,  c_line_1230);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("dr_req_c%0d", c),   word_req_o,       0);
      chk($sformatf("dr_valid_c%0d", c), mem_read_valid_o, 0);
    end
    mem_read_en_i = 1'b0;
    step();
    chk("dr_req_release", word_req_o, 0);

    // Abort after beat 1; then a fresh request from beat 0.
    mem_addr_i    = 32'h0000_3000;
    mem_read_en_i = 1'b1;
    step();
    chk("ab_addr_b0", word_addr_o, 32'h3000);
    step();
    chk("ab_addr_b1", word_addr_o, 32'h3004);
    mem_read_en_i = 1'b0;
    step();
    chk("ab_req_idle", word_req_o,       0);
    chk("ab_valid",    mem_read_valid_o, 0);
    chk("ab_data",     mem_read_data_o,  c_line_1230);
    step();
    chk("ab_valid2",   mem_read_valid_o, 0);
    mem_addr_i    = 32'h0000_0040;
    mem_read_en_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step();
      chk($sformatf("nr_addr_b%0d", b), word_addr_o, 32'h40 + 4*b);
    end
    step();
    chk("nr_valid", mem_read_valid_o, 1);
    chk("nr_data",  mem_read_data_o,  c_line_0040);
    mem_read_en_i = 1'b0;
    step();

    // Asynchronous reset in the middle of a fill.
    mem_addr_i    = 32'h0000_1234;
    mem_read_en_i = 1'b1;
    step();
    chk("mr_req_b0", word_req_o, 1);
    step();
    rstn_i = 1'b0;
    #1;
    chk("mr_req",   word_req_o,       0);
    chk("mr_valid", mem_read_valid_o, 0);
    chk("mr_addr",  word_addr_o,      0);
    chk("mr_data",  mem_read_data_o,  0);
    mem_read_en_i = 1'b0;
    step();
    rstn_i = 1'b1;
    step();
    chk("mr_idle_req", word_req_o, 0);
    mem_addr_i    = 32'h0000_0500;
    mem_read_en_i = 1'b1;
    step();
    chk("mr_restart_req",  word_req_o,  1);
    chk("mr_restart_addr", word_addr_o, 32'h500);
    mem_read_en_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
